dense_out: RTL

Final fully-connected layer of the digit detector. It reads the flattened feature vector from pixel RAM and the weight matrix from weight RAM, and multiply-accumulates one class score per output neuron. It writes the NUM_OUT saturated scores back to pixel RAM at consecutive addresses starting at `memstartzap`. Those addresses are where the downstream argmax stage reads the scores, and it starts as soon as this block raises `STOP`.

---
 rtl/dense_out.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dense_out.sv
// Final fully-connected layer: NUM_OUT neurons, each a NUM_IN-term MAC over pixel/weight RAM,
// written back as saturated scores. Define DENSE_OUT_RELU_EN to clamp negative scores to 0.
module dense_out #(
  parameter int SIZE_1           = 12,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 13,
  parameter int NUM_IN           = 64,
  parameter int NUM_OUT          = 11,
  parameter int SHIFT            = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        STOP,
  input  logic [SIZE_address_pix-1:0] memstartp,
  input  logic [SIZE_address_wei-1:0] memstartw,
  input  logic [SIZE_address_pix-1:0] memstartzap,
  output logic [SIZE_address_pix-1:0] read_addressp,
  output logic                        re,
  input  logic [SIZE_1-1:0]           qp,
  output logic [SIZE_address_wei-1:0] read_addressw,
  output logic                        re_wb,
  input  logic [SIZE_1-1:0]           qw,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic [SIZE_1-1:0]           dp,
  output logic                        we
);

  localparam int AW = 2*SIZE_1 + $clog2(NUM_IN);
  localparam int IW = $clog2(NUM_IN + 1);
  localparam int JW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IW-1:0] I_END = IW'(NUM_IN);
  localparam logic [JW-1:0] J_LAST = JW'(NUM_OUT - 1);
  localparam logic [SIZE_address_wei-1:0] ROW_STEP = SIZE_address_wei'(NUM_IN);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (SIZE_1 - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(64'sd1 <<< (SIZE_1 - 1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

  state_t                      state_q;
  logic signed [AW-1:0]        acc_q;
  logic [IW-1:0]               nxt_q;   // index of the next read to issue
  logic [JW-1:0]               j_q;
  logic [SIZE_address_wei-1:0] wrow_q;  // weight row base for neuron j_q
  logic                        re_q, we_q, stop_q;
  logic [SIZE_address_pix-1:0] rap_q, wap_q;
  logic [SIZE_address_wei-1:0] raw_q;
  logic [SIZE_1-1:0]           dp_q;

  logic signed [2*SIZE_1-1:0] prod;
  logic signed [AW-1:0]       prod_ext, shifted;
  logic [SIZE_1-1:0]          score;

  assign prod     = $signed(qp) * $signed(qw);
  assign prod_ext = AW'(prod);
  assign shifted  = acc_q >>> SHIFT;

  always_comb begin
    score = shifted[SIZE_1-1:0];
    if (shifted > SAT_MAX)      score = SAT_MAX[SIZE_1-1:0];
    else if (shifted < SAT_MIN) score = SAT_MIN[SIZE_1-1:0];
`ifdef DENSE_OUT_RELU_EN
    if (score[SIZE_1-1]) score = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      nxt_q   <= '0;
      j_q     <= '0;
      wrow_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      stop_q  <= 1'b0;
      rap_q   <= '0;
      raw_q   <= '0;
      wap_q   <= '0;
      dp_q    <= '0;
    end else if (!enable) begin
      // abort: partial sums are dropped on the next IDLE->RUN
      state_q <= S_IDLE;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          acc_q   <= '0;
          j_q     <= '0;
          wrow_q  <= memstartw;
          re_q    <= 1'b1;
          rap_q   <= memstartp;
          raw_q   <= memstartw;
          nxt_q   <= IW'(1);
          we_q    <= 1'b0;
          stop_q  <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          we_q <= 1'b0;
          // re_q marks that the read issued last edge has data on qp/qw now
          if (re_q) acc_q <= acc_q + prod_ext;
          if (nxt_q < I_END) begin
            re_q  <= 1'b1;
            rap_q <= memstartp + SIZE_address_pix'(nxt_q);
            raw_q <= wrow_q + SIZE_address_wei'(nxt_q);
            nxt_q <= nxt_q + IW'(1);
          end else begin
            re_q    <= 1'b0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          we_q  <= 1'b1;
          wap_q <= memstartzap + SIZE_address_pix'(j_q);
          dp_q  <= score;
          acc_q <= '0;
          nxt_q <= '0;
          if (j_q == J_LAST) begin
            state_q <= S_DONE;
          end else begin
            j_q     <= j_q + JW'(1);
            wrow_q  <= wrow_q + ROW_STEP;
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          re_q   <= 1'b0;
          we_q   <= 1'b0;
          stop_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign STOP           = stop_q;
  assign re             = re_q;
  assign re_wb          = re_q;
  assign we             = we_q;
  assign read_addressp  = rap_q;
  assign read_addressw  = raw_q;
  assign write_addressp = wap_q;
  assign dp             = dp_q;

endmodule
